// File: rtl/traffic_light_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_light_monitor
//  Description : Passive checker for a two-road (highway / country) traffic
//                light controller. Flags conflicting greens, illegal codes,
//                bad colour sequences, short yellows and missing all-red
//                clearance. Latches the first violation and drives a
//                fail-safe flashing output until cleared.
//  Revision    : 1.0 - initial release
// ============================================================================
module traffic_light_monitor #(
    parameter int MIN_YELLOW = 3,   // legal range 1..255
    parameter int MIN_ALLRED = 1,   // legal range 1..255
    parameter int FLASH_DIV  = 4    // cycles per flash half-period
) (
    input  logic       clk,
    input  logic       clear,
    input  logic [1:0] hwy,
    input  logic [1:0] cntry,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       flash
);

    // Light encoding shared by both roads
    localparam logic [1:0] c_red    = 2'd0;
    localparam logic [1:0] c_yellow = 2'd1;
    localparam logic [1:0] c_green  = 2'd2;
    localparam logic [1:0] c_bad    = 2'd3;

    // Violation causes; a lower code wins when several apply together
    localparam logic [2:0] c_code_none     = 3'd0;
    localparam logic [2:0] c_code_conflict = 3'd1;
    localparam logic [2:0] c_code_illegal  = 3'd2;
    localparam logic [2:0] c_code_sequence = 3'd3;
    localparam logic [2:0] c_code_short_y  = 3'd4;
    localparam logic [2:0] c_code_no_clear = 3'd5;

    localparam logic [7:0] c_sat        = 8'd255;
    localparam logic [7:0] c_min_yellow = 8'(MIN_YELLOW);
    localparam logic [7:0] c_min_allred = 8'(MIN_ALLRED);
    localparam logic [7:0] c_flash_last = 8'(FLASH_DIV - 1);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_ARMED = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next_state;

    logic [1:0] r_hwy_prev;
    logic [1:0] r_cntry_prev;
    logic [7:0] r_ycnt_hwy;
    logic [7:0] r_ycnt_cntry;
    logic [7:0] r_allred;
    logic [7:0] r_flash_cnt;

    logic       w_conflict;
    logic       w_illegal;
    logic       w_bad_seq;
    logic       w_short_yellow;
    logic       w_no_clearance;
    logic [2:0] w_viol_code;
    logic       w_violation;
    logic [7:0] w_ycnt_hwy_next;
    logic [7:0] w_ycnt_cntry_next;
    logic [7:0] w_allred_next;

    // Road is showing an active (non-red, legal) aspect
    function automatic logic f_non_red(input logic [1:0] code);
        return (code == c_yellow) || (code == c_green);
    endfunction

    // Only G->Y, Y->R, R->G and "unchanged" are legal; these three are not
    function automatic logic f_bad_step(input logic [1:0] prev, input logic [1:0] cur);
        return ((prev == c_green)  && (cur == c_red))   ||
               ((prev == c_yellow) && (cur == c_green)) ||
               ((prev == c_red)    && (cur == c_yellow));
    endfunction

    // Yellow dwell: restart at 1 on entry, count up while held, else freeze
    function automatic logic [7:0] f_ycnt_next(input logic [1:0] prev,
                                               input logic [1:0] cur,
                                               input logic [7:0] cnt);
        logic [7:0] v;
        v = cnt;
        if (cur == c_yellow) begin
            if (prev != c_yellow) begin
                v = 8'd1;
            end else if (cnt != c_sat) begin
                v = cnt + 8'd1;
            end
        end
        return v;
    endfunction

    // Rule evaluation against the previous sample and pre-update counters
    always_comb begin
        w_conflict     = f_non_red(hwy) && f_non_red(cntry);
        w_illegal      = (hwy == c_bad) || (cntry == c_bad);
        w_bad_seq      = f_bad_step(r_hwy_prev, hwy) || f_bad_step(r_cntry_prev, cntry);
        w_short_yellow = ((r_hwy_prev == c_yellow) && (hwy == c_red) &&
                          (r_ycnt_hwy < c_min_yellow)) ||
                         ((r_cntry_prev == c_yellow) && (cntry == c_red) &&
                          (r_ycnt_cntry < c_min_yellow));
        w_no_clearance = (((r_hwy_prev == c_red) && (hwy == c_green)) ||
                          ((r_cntry_prev == c_red) && (cntry == c_green))) &&
                         (r_allred < c_min_allred);

        w_viol_code = c_code_none;
        if (w_conflict) begin
            w_viol_code = c_code_conflict;
        end else if (w_illegal) begin
            w_viol_code = c_code_illegal;
        end else if (w_bad_seq) begin
            w_viol_code = c_code_sequence;
        end else if (w_short_yellow) begin
            w_viol_code = c_code_short_y;
        end else if (w_no_clearance) begin
            w_viol_code = c_code_no_clear;
        end
        w_violation = (w_viol_code != c_code_none);

        w_ycnt_hwy_next   = f_ycnt_next(r_hwy_prev, hwy, r_ycnt_hwy);
        w_ycnt_cntry_next = f_ycnt_next(r_cntry_prev, cntry, r_ycnt_cntry);
        if ((hwy == c_red) && (cntry == c_red)) begin
            w_allred_next = (r_allred == c_sat) ? c_sat : r_allred + 8'd1;
        end else begin
            w_allred_next = 8'd0;
        end
    end

    // Next-state logic: INIT lasts one sample, ARMED waits for a violation
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_INIT:  w_next_state = S_ARMED;
            S_ARMED: w_next_state = w_violation ? S_FAULT : S_ARMED;
            S_FAULT: w_next_state = S_FAULT;
            default: w_next_state = S_INIT;
        endcase
    end

    // State register; clear overrides everything
    always_ff @(posedge clk) begin
        if (clear) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // History, dwell counters, latched fault and flash generator
    always_ff @(posedge clk) begin
        if (clear) begin
            r_hwy_prev   <= c_red;
            r_cntry_prev <= c_red;
            r_ycnt_hwy   <= c_sat;
            r_ycnt_cntry <= c_sat;
            r_allred     <= c_sat;
            r_flash_cnt  <= 8'd0;
            fault        <= 1'b0;
            fault_code   <= c_code_none;
            flash        <= 1'b0;
        end else begin
            case (r_state)
                S_INIT: begin
                    // Baseline capture only; counters saturated so no dwell
                    // rule can trip on the first checked transition
                    r_hwy_prev   <= hwy;
                    r_cntry_prev <= cntry;
                    r_ycnt_hwy   <= c_sat;
                    r_ycnt_cntry <= c_sat;
                    r_allred     <= c_sat;
                end
                S_ARMED: begin
                    r_hwy_prev   <= hwy;
                    r_cntry_prev <= cntry;
                    r_ycnt_hwy   <= w_ycnt_hwy_next;
                    r_ycnt_cntry <= w_ycnt_cntry_next;
                    r_allred     <= w_allred_next;
                    if (w_violation) begin
                        fault       <= 1'b1;
                        fault_code  <= w_viol_code;
                        flash       <= 1'b1;
                        r_flash_cnt <= 8'd0;
                    end
                end
                S_FAULT: begin
                    // Outputs frozen; only the flash half-period advances
                    if (r_flash_cnt >= c_flash_last) begin
                        r_flash_cnt <= 8'd0;
                        flash       <= ~flash;
                    end else begin
                        r_flash_cnt <= r_flash_cnt + 8'd1;
                    end
                end
                default: begin
                    r_flash_cnt <= 8'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_traffic_light_monitor
//  Description : Directed vector bench for traffic_light_monitor. A default
//                instance (MIN_YELLOW=3) and a MIN_YELLOW=2 instance share
//                the same stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_light_monitor;

    localparam logic [1:0] R = 2'd0;
    localparam logic [1:0] Y = 2'd1;
    localparam logic [1:0] G = 2'd2;
    localparam logic [1:0] X = 2'd3;

    logic       clk;
    logic       clear;
    logic [1:0] hwy;
    logic [1:0] cntry;
    logic       fault_a, flash_a, fault_b, flash_b;
    logic [2:0] code_a, code_b;

    int passed;
    int total;

    typedef struct {
        logic       clr;
        logic [1:0] h;
        logic [1:0] c;
        logic [4:0] exp_a;   // {fault, fault_code, flash}, MIN_YELLOW=3
        logic [4:0] exp_b;   // same for MIN_YELLOW=2
    } vec_t;

    vec_t vecs[$];

    traffic_light_monitor #(.MIN_YELLOW(3), .MIN_ALLRED(1), .FLASH_DIV(4)) u_dut_a (
        .clk        (clk),
        .clear      (clear),
        .hwy        (hwy),
        .cntry      (cntry),
        .fault      (fault_a),
        .fault_code (code_a),
        .flash      (flash_a)
    );

    traffic_light_monitor #(.MIN_YELLOW(2), .MIN_ALLRED(1), .FLASH_DIV(4)) u_dut_b (
        .clk        (clk),
        .clear      (clear),
        .hwy        (hwy),
        .cntry      (cntry),
        .fault      (fault_b),
        .fault_code (code_b),
        .flash      (flash_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Append n identical rows; both instances expect the same outputs
    function automatic void add(input int n, input logic clr, input logic [1:0] h,
                                input logic [1:0] c, input logic f,
                                input logic [2:0] code, input logic fl);
        for (int k = 0; k < n; k++) begin
            vecs.push_back('{clr, h, c, {f, code, fl}, {f, code, fl}});
        end
    endfunction

    // Append one row where the two instances diverge
    function automatic void add2(input logic clr, input logic [1:0] h, input logic [1:0] c,
                                 input logic [4:0] ea, input logic [4:0] eb);
        vecs.push_back('{clr, h, c, ea, eb});
    endfunction

    task automatic step(input logic clr, input logic [1:0] h, input logic [1:0] c);
        @(negedge clk);
        clear = clr;
        hwy   = h;
        cntry = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int idx,
                         input logic [4:0] act, input logic [4:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s row %0d: got fault/code/flash=%b/%0d/%b, want %b/%0d/%b",
                     name, idx, act[4], act[3:1], act[0], exp[4], exp[3:1], exp[0]);
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        clear  = 1'b1;
        hwy    = R;
        cntry  = R;

        // Legal full cycle: never faults
        add(1, 1, R, R, 0, 0, 0);
        add(5, 0, G, R, 0, 0, 0);   // first row is the INIT sample
        add(3, 0, Y, R, 0, 0, 0);
        add(1, 0, R, R, 0, 0, 0);
        add(5, 0, R, G, 0, 0, 0);
        add(3, 0, R, Y, 0, 0, 0);
        add(1, 0, R, R, 0, 0, 0);
        add(1, 0, G, R, 0, 0, 0);

        // Conflict, held code, flash waveform, clear, INIT tolerance
        add(1, 1, R, R, 0, 0, 0);
        add(2, 0, G, R, 0, 0, 0);
        add(1, 0, G, Y, 1, 1, 1);   // conflict outranks R->Y sequence
        add(1, 0, X, R, 1, 1, 1);   // later illegal code ignored
        add(2, 0, R, R, 1, 1, 1);
        add(4, 0, R, R, 1, 1, 0);
        add(1, 0, R, R, 1, 1, 1);
        add(1, 1, G, Y, 0, 0, 0);   // clear beats the violation
        add(1, 0, G, Y, 0, 0, 0);   // INIT sample: unchecked
        add(1, 0, G, Y, 1, 1, 1);   // armed now

        // Short yellow: 2 cycles trips MIN_YELLOW=3 only
        add(1, 1, R, R, 0, 0, 0);
        add(2, 0, G, R, 0, 0, 0);
        add(2, 0, Y, R, 0, 0, 0);
        add2(0, R, R, 5'b1_100_1, 5'b0_000_0);
        add2(0, R, R, 5'b1_100_1, 5'b0_000_0);

        // No all-red clearance between Y/R and R/G
        add(1, 1, R, R, 0, 0, 0);
        add(1, 0, G, R, 0, 0, 0);
        add(3, 0, Y, R, 0, 0, 0);
        add(1, 0, R, G, 1, 5, 1);

        // Illegal code outranks a bad cntry Y->G step
        add(1, 1, R, R, 0, 0, 0);
        add(1, 0, R, Y, 0, 0, 0);
        add(1, 0, X, G, 1, 2, 1);

        // Clear asserted in ARMED alongside an illegal sample
        add(1, 1, R, R, 0, 0, 0);
        add(1, 0, R, R, 0, 0, 0);
        add(1, 1, X, X, 0, 0, 0);
        add(1, 0, X, X, 0, 0, 0);
        add(1, 0, X, X, 1, 2, 1);

        foreach (vecs[i]) begin
            step(vecs[i].clr, vecs[i].h, vecs[i].c);
            check("vecA", i, {fault_a, code_a, flash_a}, vecs[i].exp_a);
            check("vecB", i, {fault_b, code_b, flash_b}, vecs[i].exp_b);
        end

        // Yellow counter must saturate: 257 yellow samples then red is legal
        step(1, R, R);
        step(0, G, R);
        step(0, G, R);
        for (int k = 0; k < 257; k++) step(0, Y, R);
        step(0, R, R);
        check("ysat", 0, {fault_a, code_a, flash_a}, 5'b0_000_0);

        // All-red counter must saturate: 256 all-red samples then R->G is legal
        step(1, R, R);
        step(0, G, R);
        step(0, G, R);
        step(0, Y, R);
        step(0, Y, R);
        step(0, Y, R);
        for (int k = 0; k < 256; k++) step(0, R, R);
        step(0, G, R);
        check("rsat", 0, {fault_a, code_a, flash_a}, 5'b0_000_0);

        // Clear mid-FAULT returns every output to zero
        step(0, X, R);
        check("flt", 0, {fault_a, code_a, flash_a}, 5'b1_010_1);
        step(1, X, R);
        check("clr", 0, {fault_a, code_a, flash_a}, 5'b0_000_0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
